// File: rtl/sr_pkg.sv
// sr_pkg: shared shift-register transmitter types and sizes for the display path.
package sr_pkg;
    localparam int SR_WIDTH = 8;
    localparam int DIGITS   = 6;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOW    = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;
    localparam logic [1:0] ST_STROBE = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_LOW    = ST_LOW,
        S_HIGH   = ST_HIGH,
        S_STROBE = ST_STROBE
    } state_t;
endpackage

// File: rtl/sr_tx_if.sv
// sr_tx_if: parallel load handshake and serial pins between controller and sr_tx.
interface sr_tx_if
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
);
    logic             i_load;
    logic [WIDTH-1:0] i_data;
    logic             o_busy;
    logic             o_sclk;
    logic             o_sdata;
    logic             o_strobe;
    modport master (output i_load, i_data, input o_busy, o_sclk, o_sdata, o_strobe);
    modport slave  (input i_load, i_data, output o_busy, o_sclk, o_sdata, o_strobe);
endinterface

// File: rtl/sr_tx_div.sv
// sr_tx_div: half-period tick counter; tick is high for one cycle every DIV cycles after restart.
module sr_tx_div #(
    parameter int DIV = 2
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(DIV + 1);
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(DIV - 1);
    always_ff @(posedge i_clk) begin
        if (i_rst || restart) cnt <= '0;
        else                  cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/sr_tx.sv
// sr_tx: MSB-first serial transmitter for 74HC595-style chains.
// Define SR_TX_STROBE_EN to add the storage-latch strobe after each word.
module sr_tx
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH,
    parameter int DIV   = 2
`ifdef SR_TX_STROBE_EN
    ,
    parameter int STB_LEN = 1
`endif
)(
    input  logic     i_clk,
    input  logic     i_rst,
    sr_tx_if.slave   bus
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    state_t           state, state_nx;
    logic [WIDTH-2:0] sreg, sreg_nx;
    logic [BW-1:0]    bit_cnt, bit_nx;
    logic             busy, busy_nx, sclk, sclk_nx, sdata, sdata_nx;
    logic             tick;
    // Divider is held cleared while idle so the first half-period starts on the accepting edge.
    sr_tx_div #(.DIV(DIV)) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .restart (state == S_IDLE),
        .tick    (tick)
    );
`ifdef SR_TX_STROBE_EN
    localparam int SW = $clog2(STB_LEN + 1);
    logic [SW-1:0] stb_cnt, stb_nx;
    logic          strobe, strobe_nx;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stb_cnt <= '0;
            strobe  <= 1'b0;
        end else begin
            stb_cnt <= stb_nx;
            strobe  <= strobe_nx;
        end
    end
    assign bus.o_strobe = strobe;
`else
    assign bus.o_strobe = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            bit_cnt <= bit_nx;
            busy    <= busy_nx;
            sclk    <= sclk_nx;
            sdata   <= sdata_nx;
        end
    end
    always_comb begin
        state_nx  = state;
        sreg_nx   = sreg;
        bit_nx    = bit_cnt;
        busy_nx   = busy;
        sclk_nx   = sclk;
        sdata_nx  = sdata;
`ifdef SR_TX_STROBE_EN
        stb_nx    = stb_cnt;
        strobe_nx = strobe;
`endif
        case (state)
            S_IDLE: if (bus.i_load) begin
                state_nx = S_LOW;
                sreg_nx  = bus.i_data[WIDTH-2:0];
                bit_nx   = '0;
                busy_nx  = 1'b1;
                sclk_nx  = 1'b0;
                sdata_nx = bus.i_data[WIDTH-1];
            end
            S_LOW: if (tick) begin
                state_nx = S_HIGH;
                sclk_nx  = 1'b1;
            end
            S_HIGH: if (tick) begin
                sclk_nx = 1'b0;
                if (bit_cnt != LAST) begin
                    state_nx = S_LOW;
                    sdata_nx = sreg[WIDTH-2];
                    sreg_nx  = sreg << 1;
                    bit_nx   = bit_cnt + 1'b1;
                end else begin
`ifdef SR_TX_STROBE_EN
                    state_nx  = S_STROBE;
                    strobe_nx = 1'b1;
                    stb_nx    = '0;
`else
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                    sdata_nx = 1'b0;
`endif
                end
            end
`ifdef SR_TX_STROBE_EN
            S_STROBE: if (stb_cnt == SW'(STB_LEN - 1)) begin
                state_nx  = S_IDLE;
                strobe_nx = 1'b0;
                busy_nx   = 1'b0;
                sdata_nx  = 1'b0;
            end else begin
                stb_nx = stb_cnt + 1'b1;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end
    assign bus.o_busy  = busy;
    assign bus.o_sclk  = sclk;
    assign bus.o_sdata = sdata;
endmodule
